// File: rtl/dip_uart_reporter.sv
// rtl/dip_uart_reporter.sv - debounced DIP switch reporter over an 8N1 UART Tx line
//
// Purpose:
//   Synchronizes and debounces the 8 trainer DIP switches as one vector. Every
//   accepted change, and every send_now request, queues one 8N1 frame carrying
//   dip_stable to the AVR.
//
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous active-high reset
//   trainer_dip  in   8  raw switch levels, asynchronous to clk
//   avr_rx_busy  in   1  AVR Rx buffer full; blocks the start of a new frame
//   send_now     in   1  one-cycle pulse: report dip_stable even if unchanged
//   avr_rx       out  1  serial Tx line to AVR, idle high, registered
//   dip_stable   out  8  debounced switch value
//   tx_busy      out  1  high while a frame is on the line
module dip_uart_reporter #(
  parameter int CLK_PER_BIT     = 100,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] trainer_dip,
  input  logic       avr_rx_busy,
  input  logic       send_now,
  output logic       avr_rx,
  output logic [7:0] dip_stable,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BIT_W = $clog2(CLK_PER_BIT + 1);
  localparam logic [CNT_W-1:0] DB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(CLK_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Two-flop synchronizers
  logic [7:0] dip_meta, sync_dip;
  logic       busy_meta, busy_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dip_meta  <= '0;
      sync_dip  <= '0;
      busy_meta <= 1'b0;
      busy_sync <= 1'b0;
    end else begin
      dip_meta  <= trainer_dip;
      sync_dip  <= dip_meta;
      busy_meta <= avr_rx_busy;
      busy_sync <= busy_meta;
    end
  end

  // Whole-vector debounce: any bit flip restarts the hold count, so
  // dip_stable only ever takes a value that held still for the full window.
  logic [7:0]       cand;
  logic [CNT_W-1:0] db_cnt;
  logic             change_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand       <= '0;
      db_cnt     <= '0;
      dip_stable <= '0;
      change_q   <= 1'b0;
    end else begin
      change_q <= 1'b0;
      if (sync_dip != cand) begin
        cand   <= sync_dip;
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        // Counter saturates; reloading the same value is not a change.
        dip_stable <= cand;
        change_q   <= (cand != dip_stable);
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Requests are registered once so pending rises the cycle after the
  // load / the send_now sample.
  logic send_q;
  logic pending;
  logic leave_idle;
  state_t state;

  assign leave_idle = (state == IDLE) && pending && !busy_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      send_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      send_q <= send_now;
      // Set wins over clear: a change seen while a frame starts queues another.
      if (change_q || send_q)
        pending <= 1'b1;
      else if (leave_idle)
        pending <= 1'b0;
    end
  end

  // Transmit FSM with registered line and busy outputs
  logic [BIT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      avr_rx  <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          avr_rx  <= 1'b1;
          tx_busy <= 1'b0;
          bit_cnt <= '0;
          bit_idx <= '0;
          if (leave_idle) begin
            shreg   <= dip_stable;
            state   <= START;
            avr_rx  <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_cnt == BIT_MAX) begin
            bit_cnt <= '0;
            state   <= DATA;
            avr_rx  <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == BIT_MAX) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state  <= STOP;
              avr_rx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= {1'b0, shreg[7:1]};
              avr_rx  <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == BIT_MAX) begin
            bit_cnt <= '0;
            state   <= IDLE;
            tx_busy <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          avr_rx  <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dip_uart_reporter.sv
// tb/tb_dip_uart_reporter.sv - directed self-checking bench for dip_uart_reporter
module tb_dip_uart_reporter;

  localparam int CPB = 4;
  localparam int DBC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] trainer_dip;
  logic       avr_rx_busy;
  logic       send_now;
  logic       avr_rx;
  logic [7:0] dip_stable;
  logic       tx_busy;

  int checks   = 0;
  int failures = 0;

  int frame_cnt = 0;
  int busy_cnt  = 0;
  bit low_seen  = 0;
  logic prev_busy = 1'b0;

  dip_uart_reporter #(
    .CLK_PER_BIT    (CPB),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trainer_dip(trainer_dip),
    .avr_rx_busy(avr_rx_busy),
    .send_now   (send_now),
    .avr_rx     (avr_rx),
    .dip_stable (dip_stable),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_busy === 1'b1 && prev_busy !== 1'b1) frame_cnt++;
    if (tx_busy === 1'b1) busy_cnt++;
    if (avr_rx === 1'b0) low_seen = 1;
    prev_busy = tx_busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Samples one frame at mid-bit. With started=1 the current negedge is
  // taken as the first cycle of the start bit.
  task automatic recv_frame(input bit started, input int max_wait,
                            output logic [7:0] data, output int waited,
                            output bit st_ok, output bit sp_ok, output bit to);
    to = 0; waited = 0; data = '0; st_ok = 0; sp_ok = 0;
    if (!started) begin
      while (waited < max_wait) begin
        @(negedge clk);
        waited++;
        if (avr_rx === 1'b0) break;
      end
      if (avr_rx !== 1'b0) begin
        to = 1;
        return;
      end
    end
    repeat (CPB / 2) @(negedge clk);
    st_ok = (avr_rx === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      data[i] = avr_rx;
    end
    repeat (CPB) @(negedge clk);
    sp_ok = (avr_rx === 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] d;
  int  w, f0, b0;
  bit  st, sp, to;

  initial begin
    rst = 1'b1; trainer_dip = 8'h00; avr_rx_busy = 1'b0; send_now = 1'b0;
    #1;
    check("rst_avr_rx", avr_rx, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_dip_stable", dip_stable, 0);
    repeat (3) @(negedge clk);

    // 1: settle 0xA5 from reset, one 40-cycle frame
    f0 = frame_cnt; b0 = busy_cnt;
    rst = 1'b0; trainer_dip = 8'hA5;
    recv_frame(0, 100, d, w, st, sp, to);
    check("t1_timeout", to, 0);
    check("t1_dip_stable", dip_stable, 8'hA5);
    check("t1_start", st, 1);
    check("t1_data", d, 8'hA5);
    check("t1_stop", sp, 1);
    repeat (20) @(negedge clk);
    check("t1_busy_cycles", busy_cnt - b0, 40);
    check("t1_frames", frame_cnt - f0, 1);

    // 2: toggling faster than the debounce window is never accepted
    trainer_dip = 8'h00;
    do_reset();
    repeat (5) @(negedge clk);
    f0 = frame_cnt; low_seen = 0;
    for (int i = 0; i < 20; i++) begin
      repeat (5) @(negedge clk);
      trainer_dip = trainer_dip ^ 8'h01;
    end
    check("t2_dip_stable", dip_stable, 8'h00);
    repeat (10) @(negedge clk);
    check("t2_low_seen", low_seen, 0);
    check("t2_frames", frame_cnt - f0, 0);

    // 3: AVR busy blocks the start; frame follows the release
    avr_rx_busy = 1'b1; trainer_dip = 8'h3C; low_seen = 0;
    repeat (30) @(negedge clk);
    check("t3_dip_stable", dip_stable, 8'h3C);
    check("t3_blocked", low_seen, 0);
    avr_rx_busy = 1'b0;
    recv_frame(0, 10, d, w, st, sp, to);
    check("t3_timeout", to, 0);
    check("t3_latency_2_3", (w >= 2 && w <= 3), 1);
    check("t3_data", d, 8'h3C);
    check("t3_stop", sp, 1);
    repeat (10) @(negedge clk);

    // 4: changes mid-frame coalesce into one back-to-back frame
    f0 = frame_cnt;
    trainer_dip = 8'h11;
    fork
      recv_frame(0, 100, d, w, st, sp, to);
      begin
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (avr_rx === 1'b0) break;
        end
        repeat (5) @(negedge clk);
        trainer_dip = 8'h22;
        repeat (15) @(negedge clk);
        trainer_dip = 8'h33;
      end
    join
    check("t4_first_timeout", to, 0);
    check("t4_first_data", d, 8'h11);
    check("t4_first_stop", sp, 1);
    recv_frame(0, 10, d, w, st, sp, to);
    check("t4_second_timeout", to, 0);
    check("t4_back_to_back_gap", w, 3);
    check("t4_second_data", d, 8'h33);
    repeat (60) @(negedge clk);
    check("t4_frames", frame_cnt - f0, 2);

    // 5: send_now repeats an unchanged value, start bit at edge N+2
    trainer_dip = 8'h5A;
    recv_frame(0, 100, d, w, st, sp, to);
    check("t5_change_data", d, 8'h5A);
    repeat (10) @(negedge clk);
    send_now = 1'b1;
    @(negedge clk);
    send_now = 1'b0;
    check("t5_after_n", avr_rx, 1);
    @(negedge clk);
    check("t5_after_n1", avr_rx, 1);
    @(negedge clk);
    check("t5_after_n2", avr_rx, 0);
    recv_frame(1, 0, d, w, st, sp, to);
    check("t5_data", d, 8'h5A);
    check("t5_stop", sp, 1);
    repeat (10) @(negedge clk);

    // 6: reset during DATA bit 3 drops the frame immediately
    trainer_dip = 8'hF0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (avr_rx === 1'b0) break;
    end
    repeat (4 * CPB + 1) @(negedge clk);
    check("t6_pre_bit3", avr_rx, 0);
    rst = 1'b1;
    #1;
    check("t6_rst_avr_rx", avr_rx, 1);
    check("t6_rst_tx_busy", tx_busy, 0);
    check("t6_rst_dip_stable", dip_stable, 0);
    trainer_dip = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    f0 = frame_cnt; low_seen = 0;
    repeat (40) @(negedge clk);
    check("t6_no_frame", frame_cnt - f0, 0);
    check("t6_line_idle", low_seen, 0);
    trainer_dip = 8'h77;
    recv_frame(0, 100, d, w, st, sp, to);
    check("t6_timeout", to, 0);
    check("t6_data", d, 8'h77);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
